mem_arb: RTL and testbench

- Arbiter and byte sequencer sharing the single byte-wide RAM port between instruction fetch (IF) and load/store (LS).
- Splits each granted access into 1, 2 or 4 sequential byte transfers, reassembles read data little-endian, and returns a one-cycle done pulse to the owner.
- Sits between the fetch/LS units and the RAM pins. It replaces ad-hoc port sharing with explicit priority and a starvation guard.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/mem_byte_seq.sv | 106 ++++++++++
 rtl/mem_arb.sv | 162 ++++++++++++++++
 tb/tb_mem_arb.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the IF/LS memory arbiter and its byte sequencer.
package mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RWAIT,
        WR,
        DONE
    } state_e;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_e;

    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd3;

    // An encoding of 2 is widened to a full word.
    function automatic logic [2:0] len_to_n(input logic [1:0] len);
        case (len)
            LEN_B:   return 3'd1;
            LEN_H:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte sequencer: walks N consecutive byte addresses, drives write bytes and
// packs read bytes little-endian into a 32-bit result.
module mem_byte_seq
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [2:0]        n_i,
    input  logic              we_i,
    input  logic [31:0]       wdata_i,
    input  logic              issue_i,
    input  logic [7:0]        mem_din_i,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic [7:0]        mem_dout_o,
    output logic              last_o,
    output logic [31:0]       result_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        nm1_q, nm1_d;
    logic [1:0]        rcnt_q, rcnt_d;
    logic              we_q, we_d;
    logic              rd_vld_q, rd_vld_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       acc_q, acc_d;
    logic [7:0]        dout_q, dout_d;

    assign last_o     = (cnt_q == nm1_q);
    assign mem_a_o    = addr_q;
    assign mem_dout_o = dout_q;
    // Exposes the word including the byte arriving this cycle, so the owner
    // can latch the complete result on the final collect cycle.
    assign result_o   = acc_d;

    always_comb begin
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        nm1_d    = nm1_q;
        rcnt_d   = rcnt_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        acc_d    = acc_q;
        dout_d   = dout_q;
        rd_vld_d = issue_i && !we_q;

        // RAM returns the byte addressed in the previous cycle.
        if (rd_vld_q) begin
            acc_d[{rcnt_q, 3'b000} +: 8] = mem_din_i;
            rcnt_d = rcnt_q + 2'd1;
        end

        if (start_i) begin
            addr_d   = addr_i;
            cnt_d    = '0;
            rcnt_d   = '0;
            we_d     = we_i;
            wdata_d  = wdata_i;
            acc_d    = '0;
            rd_vld_d = 1'b0;
            case (n_i)
                3'd1:    nm1_d = 2'd0;
                3'd2:    nm1_d = 2'd1;
                default: nm1_d = 2'd3;
            endcase
            if (we_i) begin
                dout_d = wdata_i[7:0];
            end
        end else if (issue_i && !last_o) begin
            addr_d = addr_q + 1'b1;
            cnt_d  = cnt_q + 2'd1;
            if (we_q) begin
                dout_d = wdata_q[{cnt_d, 3'b000} +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            cnt_q    <= '0;
            nm1_q    <= '0;
            rcnt_q   <= '0;
            we_q     <= 1'b0;
            rd_vld_q <= 1'b0;
            wdata_q  <= '0;
            acc_q    <= '0;
            dout_q   <= '0;
        end else begin
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            nm1_q    <= nm1_d;
            rcnt_q   <= rcnt_d;
            we_q     <= we_d;
            rd_vld_q <= rd_vld_d;
            wdata_q  <= wdata_d;
            acc_q    <= acc_d;
            dout_q   <= dout_d;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Arbitrates the single byte-wide RAM port between instruction fetch and
// load/store; LS has priority, bounded by a starvation counter for IF.
module mem_arb
    import mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [1:0]        ls_len,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    output logic [7:0]        mem_dout,
    input  logic [7:0]        mem_din
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_e      state_q;
    owner_e      owner_q;
    logic [3:0]  starve_q, starve_d;
    logic        if_done_q, ls_done_q, mem_wr_q;
    logic [31:0] if_data_q, ls_rdata_q;

    logic              grant_if, grant_ls;
    logic              seq_start, seq_we, seq_issue, seq_last;
    logic [ADDR_W-1:0] seq_addr;
    logic [2:0]        seq_n;
    logic [31:0]       seq_result;

    assign if_done  = if_done_q;
    assign ls_done  = ls_done_q;
    assign if_data  = if_data_q;
    assign ls_rdata = ls_rdata_q;
    assign mem_wr   = mem_wr_q;

    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (state_q == IDLE) begin
            if (if_req && !if_flush && (!ls_req || starve_q == LIMIT)) begin
                grant_if = 1'b1;
            end else if (ls_req) begin
                grant_ls = 1'b1;
            end
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!if_req || grant_if) begin
            starve_d = '0;
        end else if (grant_ls && starve_q < LIMIT) begin
            starve_d = starve_q + 4'd1;
        end
    end

    assign seq_start = grant_if || grant_ls;
    assign seq_addr  = grant_if ? if_addr : ls_addr;
    assign seq_n     = grant_if ? 3'd4 : len_to_n(ls_len);
    assign seq_we    = grant_ls && ls_we;
    assign seq_issue = (state_q == RD) || (state_q == WR);

    mem_byte_seq #(
        .ADDR_W (ADDR_W)
    ) u_seq (
        .clk        (clk),
        .rst        (rst),
        .start_i    (seq_start),
        .addr_i     (seq_addr),
        .n_i        (seq_n),
        .we_i       (seq_we),
        .wdata_i    (ls_wdata),
        .issue_i    (seq_issue),
        .mem_din_i  (mem_din),
        .mem_a_o    (mem_a),
        .mem_dout_o (mem_dout),
        .last_o     (seq_last),
        .result_o   (seq_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            starve_q   <= '0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
            mem_wr_q   <= 1'b0;
        end else begin
            starve_q  <= starve_d;
            if_done_q <= 1'b0;
            ls_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_if) begin
                        owner_q <= OWN_IF;
                        state_q <= RD;
                    end else if (grant_ls) begin
                        owner_q <= OWN_LS;
                        if (ls_we) begin
                            state_q  <= WR;
                            mem_wr_q <= 1'b1;
                        end else begin
                            state_q <= RD;
                        end
                    end
                end
                RD: begin
                    if (owner_q == OWN_IF && if_flush) begin
                        state_q <= IDLE;
                    end else if (seq_last) begin
                        state_q <= RWAIT;
                    end
                end
                RWAIT: begin
                    if (owner_q == OWN_IF && if_flush) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= DONE;
                        if (owner_q == OWN_IF) begin
                            if_done_q <= 1'b1;
                            if_data_q <= seq_result;
                        end else begin
                            ls_done_q  <= 1'b1;
                            ls_rdata_q <= seq_result;
                        end
                    end
                end
                // Stores always run to completion regardless of ls_req.
                WR: begin
                    if (seq_last) begin
                        mem_wr_q  <= 1'b0;
                        ls_done_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed vector table, corner sequences,
// and randomized traffic against a transaction-level timing model.
module tb_mem_arb;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_flush = 1'b0;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [31:0] ls_addr = '0;
    logic [1:0]  ls_len = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din = '0;

    int errors = 0;
    int checks = 0;

    // 4 KiB RAM, address aliased on the low 12 bits.
    logic [7:0] ram    [0:4095];
    logic [7:0] shadow [0:4095];

    mem_arb #(
        .STARVE_LIMIT (LIMIT),
        .ADDR_W       (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_flush (if_flush),
        .if_done  (if_done),
        .if_data  (if_data),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_addr  (ls_addr),
        .ls_len   (ls_len),
        .ls_wdata (ls_wdata),
        .ls_done  (ls_done),
        .ls_rdata (ls_rdata),
        .mem_a    (mem_a),
        .mem_wr   (mem_wr),
        .mem_dout (mem_dout),
        .mem_din  (mem_din)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
        mem_din <= ram[mem_a[11:0]];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          is_ls;
        bit          we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] len);
        return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_a"}, mem_a, 32'h0);
        chk({tag, "_mem_wr"}, {31'b0, mem_wr}, 32'h0);
        chk({tag, "_mem_dout"}, {24'b0, mem_dout}, 32'h0);
        chk({tag, "_if_done"}, {31'b0, if_done}, 32'h0);
        chk({tag, "_ls_done"}, {31'b0, ls_done}, 32'h0);
        chk({tag, "_if_data"}, if_data, 32'h0);
        chk({tag, "_ls_rdata"}, ls_rdata, 32'h0);
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int          n;
        logic [31:0] a;
        logic [31:0] wd;
        n  = v.is_ls ? nbytes(v.len) : 4;
        wd = v.wdata;
        if (v.is_ls) begin
            ls_req = 1'b1; ls_we = v.we; ls_len = v.len; ls_addr = v.addr; ls_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        for (int t = 1; t <= v.lat; t++) begin
            @(negedge clk);
            if (t <= n) begin
                a = v.addr + 32'(t - 1);
                chk($sformatf("v%0d_mem_a_c%0d", id, t), mem_a, a);
                chk($sformatf("v%0d_mem_wr_c%0d", id, t), {31'b0, mem_wr}, {31'b0, v.we});
                if (v.we) chk($sformatf("v%0d_dout_c%0d", id, t), {24'b0, mem_dout}, {24'b0, wd[8*(t-1) +: 8]});
            end else begin
                chk($sformatf("v%0d_mem_wr_c%0d", id, t), {31'b0, mem_wr}, 32'h0);
            end
            chk($sformatf("v%0d_if_done_c%0d", id, t), {31'b0, if_done}, {31'b0, (!v.is_ls && t == v.lat)});
            chk($sformatf("v%0d_ls_done_c%0d", id, t), {31'b0, ls_done}, {31'b0, (v.is_ls && t == v.lat)});
        end
        if (!v.is_ls) chk($sformatf("v%0d_if_data", id), if_data, v.exp);
        else if (!v.we) chk($sformatf("v%0d_ls_rdata", id), ls_rdata, v.exp);
        if_req = 1'b0;
        ls_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int          got;
        string       ord;
        bit          rr_if, rr_ls;
        // random-phase model state
        int          c, g, done_c, k, s, m_n;
        bit          busy, m_ls, m_we, edone, gi, gl;
        logic [31:0] m_addr, m_wdata, m_res, exp_a, last_a;
        logic [7:0]  exp_dout, last_dout;
        logic        exp_wr;

        for (int i = 0; i < 4096; i++) ram[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h3C;
        ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
        ram[12'h020] = 8'h7E;
        ram[12'h040] = 8'h11; ram[12'h041] = 8'h22;
        ram[12'h050] = 8'h01; ram[12'h051] = 8'h02; ram[12'h052] = 8'h03; ram[12'h053] = 8'h04;
        ram[12'hFFE] = 8'hA1; ram[12'hFFF] = 8'hB2; ram[12'h000] = 8'hC3; ram[12'h001] = 8'hD4;

        //          is_ls we len    addr          wdata         exp           lat
        vecs[0] = '{1'b0, 1'b0, 2'd0, 32'h0000_0100, 32'h0,        32'h0000_0513, 6};
        vecs[1] = '{1'b1, 1'b0, 2'd0, 32'h0000_0020, 32'h0,        32'h0000_007E, 3};
        vecs[2] = '{1'b1, 1'b0, 2'd1, 32'h0000_0040, 32'h0,        32'h0000_2211, 4};
        vecs[3] = '{1'b1, 1'b0, 2'd2, 32'h0000_0050, 32'h0,        32'h0403_0201, 6};
        vecs[4] = '{1'b1, 1'b0, 2'd3, 32'hFFFF_FFFE, 32'h0,        32'hD4C3_B2A1, 6};
        vecs[5] = '{1'b1, 1'b1, 2'd1, 32'h0003_0004, 32'hAABBCCDD, 32'h0,         3};
        vecs[6] = '{1'b1, 1'b1, 2'd0, 32'h0000_0060, 32'h12345678, 32'h0,         2};
        vecs[7] = '{1'b1, 1'b1, 2'd3, 32'h0000_0070, 32'hCAFEF00D, 32'h0,         5};
        vecs[8] = '{1'b0, 1'b0, 2'd0, 32'hFFFF_FFFE, 32'h0,        32'hD4C3_B2A1, 6};
        vecs[9] = '{1'b1, 1'b0, 2'd1, 32'h0003_0004, 32'h0,        32'h0000_CCDD, 4};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        chk("ram_30004", {24'b0, ram[12'h004]}, 32'hDD);
        chk("ram_30005", {24'b0, ram[12'h005]}, 32'hCC);
        chk("ram_60", {24'b0, ram[12'h060]}, 32'h78);
        chk("ram_70_73", {ram[12'h073], ram[12'h072], ram[12'h071], ram[12'h070]}, 32'hCAFEF00D);

        // Reset in G+2 of an IF read
        if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midrst");
        rst = 1'b0; if_req = 1'b0;
        @(negedge clk);
        run_vec(20, vecs[1]);

        // Flush in G+3 of an IF read; pending LS byte load wins in G+4
        if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b0; ls_len = 2'd0; ls_addr = 32'h20;
        @(negedge clk);
        chk("fl_if_done_g2", {31'b0, if_done}, 32'h0);
        @(negedge clk);
        if_flush = 1'b1;
        @(negedge clk);
        chk("fl_if_done_g4", {31'b0, if_done}, 32'h0);
        if_flush = 1'b0; if_req = 1'b0;
        @(negedge clk);
        chk("fl_ls_mem_a_g5", mem_a, 32'h20);
        chk("fl_ls_mem_wr_g5", {31'b0, mem_wr}, 32'h0);
        @(negedge clk);
        chk("fl_ls_done_g6", {31'b0, ls_done}, 32'h0);
        @(negedge clk);
        chk("fl_ls_done_g7", {31'b0, ls_done}, 32'h1);
        chk("fl_ls_rdata", ls_rdata, 32'h0000_007E);
        chk("fl_if_done_g7", {31'b0, if_done}, 32'h0);
        ls_req = 1'b0;
        @(negedge clk);
        chk("fl_if_done_g8", {31'b0, if_done}, 32'h0);
        chk("fl_if_data", if_data, 32'h0);

        // Flush held in IDLE blocks the IF grant
        if_req = 1'b1; if_addr = 32'h500; if_flush = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("flidle_mem_a_%0d", i), mem_a, 32'h20);
            chk($sformatf("flidle_if_done_%0d", i), {31'b0, if_done}, 32'h0);
        end
        if_req = 1'b0; if_flush = 1'b0;
        @(negedge clk);

        // Contention: both requesters re-request after every completion
        if_req = 1'b1; if_addr = 32'h200;
        ls_req = 1'b1; ls_we = 1'b0; ls_len = 2'd0; ls_addr = 32'h300;
        got = 0; ord = ""; rr_if = 1'b0; rr_ls = 1'b0;
        for (int t = 0; t < 300 && got < 10; t++) begin
            @(negedge clk);
            if (rr_ls) begin ls_req = 1'b1; rr_ls = 1'b0; end
            if (rr_if) begin if_req = 1'b1; rr_if = 1'b0; end
            if (ls_done) begin ord = {ord, "L"}; ls_req = 1'b0; rr_ls = 1'b1; got++; end
            if (if_done) begin ord = {ord, "I"}; if_req = 1'b0; rr_if = 1'b1; got++; end
        end
        if_req = 1'b0; ls_req = 1'b0;
        chk("cont_count", 32'(got), 32'd10);
        checks++;
        if (ord != "LLLLILLLLI") begin
            errors++;
            $display("FAIL cont_order: got %s expected LLLLILLLLI", ord);
        end

        // Randomized traffic against a transaction-level model
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        shadow = ram;
        busy = 1'b0; s = 0; last_a = '0; last_dout = '0;
        c = 0; g = 0; done_c = -1; m_n = 0; m_ls = 1'b0; m_we = 1'b0;
        m_addr = '0; m_wdata = '0; m_res = '0;
        for (int it = 0; it < 1500; it++) begin
            exp_wr = 1'b0; exp_a = last_a; exp_dout = last_dout;
            if (busy && c >= g + 1 && c <= g + m_n) begin
                k = c - g - 1;
                exp_a = m_addr + 32'(k);
                if (m_we) begin
                    exp_wr = 1'b1;
                    exp_dout = m_wdata[8*k +: 8];
                end
            end
            chk($sformatf("r%0d_mem_a", c), mem_a, exp_a);
            chk($sformatf("r%0d_mem_wr", c), {31'b0, mem_wr}, {31'b0, exp_wr});
            chk($sformatf("r%0d_mem_dout", c), {24'b0, mem_dout}, {24'b0, exp_dout});
            last_a = exp_a; last_dout = exp_dout;

            edone = busy && (c == done_c);
            chk($sformatf("r%0d_if_done", c), {31'b0, if_done}, {31'b0, (edone && !m_ls)});
            chk($sformatf("r%0d_ls_done", c), {31'b0, ls_done}, {31'b0, (edone && m_ls)});
            if (edone) begin
                if (!m_ls) begin
                    chk($sformatf("r%0d_if_data", c), if_data, m_res);
                    if_req = 1'b0;
                end else begin
                    if (!m_we) chk($sformatf("r%0d_ls_rdata", c), ls_rdata, m_res);
                    ls_req = 1'b0;
                end
                busy = 1'b0;
            end

            if (!if_req && !(edone && !m_ls) && $urandom_range(0, 3) == 0) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            if (!ls_req && !(edone && m_ls) && $urandom_range(0, 2) == 0) begin
                ls_req = 1'b1;
                ls_we = 1'($urandom_range(0, 1));
                ls_len = 2'($urandom_range(0, 3));
                ls_wdata = $urandom;
                ls_addr = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
            end

            gi = 1'b0; gl = 1'b0;
            if (!busy && !edone) begin
                if (if_req && (!ls_req || s == LIMIT)) gi = 1'b1;
                else if (ls_req) gl = 1'b1;
            end
            if (!if_req || gi) s = 0;
            else if (gl && s < LIMIT) s = s + 1;

            if (gi || gl) begin
                busy = 1'b1; g = c; m_ls = gl;
                m_we = gl && ls_we;
                m_addr = gl ? ls_addr : if_addr;
                m_wdata = ls_wdata;
                m_n = gl ? nbytes(ls_len) : 4;
                done_c = m_we ? c + m_n + 1 : c + m_n + 2;
                m_res = '0;
                for (int b = 0; b < m_n; b++) begin
                    exp_a = m_addr + 32'(b);
                    if (m_we) shadow[exp_a[11:0]] = m_wdata[8*b +: 8];
                    else m_res[8*b +: 8] = shadow[exp_a[11:0]];
                end
            end
            @(negedge clk);
            c++;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
